// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, and data-memory waits with a timeout into a sticky error state.
module hazard_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pipe_hold,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              bus_error_q, bus_error_d;
  logic              load_use;
  logic              mem_stall;

  // $zero is never a real destination, so it cannot create a hazard.
  assign load_use = ex_memRead & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mem_stall = mem_req & ~mem_ready;

  // Pipeline control outputs, decoded from state and current stage inputs.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_hold   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        StMemWait: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Next state, wait counter, sticky error and saturating stall counter.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    bus_error_d   = bus_error_q;
    stall_count_d = stall_count_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = TO_W'(1);
        end
      end
      StMemWait: begin
        // Dropping mem_req mid-wait is treated as completion.
        if (mem_ready || !mem_req) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
          state_d     = StError;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d     = StError;
        bus_error_d = 1'b1;
      end
    endcase
    if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Synchronous reset discards any partial wait and clears the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      bus_error_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_error_q   <= bus_error_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus_error   = bus_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench: each vector pushes its expected outputs; a negedge monitor
// pops and compares against what the DUT presents in that cycle.
module tb_hazard_sequencer;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned TO_W        = 7;
  localparam int unsigned CNT_W       = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_memRead = 1'b0, branch_taken = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold, bus_error;
  logic [CNT_W-1:0] stall_count;

  typedef struct {
    string            name;
    logic [4:0]       ctl;  // {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold}
    logic             be;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_memRead  (ex_memRead),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .pipe_hold   (pipe_hold),
    .bus_error   (bus_error),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle presents one output set; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold};
      checks++;
      if (act !== e.ctl || bus_error !== e.be || stall_count !== e.sc) begin
        errors++;
        $display("FAIL %s: got ctl=%b be=%b sc=%0d, want ctl=%b be=%b sc=%0d",
                 e.name, act, bus_error, stall_count, e.ctl, e.be, e.sc);
      end
    end
  end

  localparam logic [4:0] Run  = 5'b11000;
  localparam logic [4:0] Bub  = 5'b00100;
  localparam logic [4:0] Flu  = 5'b11010;
  localparam logic [4:0] Hold = 5'b00001;
  localparam logic [4:0] Err  = 5'b00101;

  task automatic step(input string name, input logic rst, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic br, input logic req, input logic rdy,
                      input logic [4:0] ctl, input logic be, input int sc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ex_memRead = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; branch_taken = br; mem_req = req; mem_ready = rdy;
    e.name = name; e.ctl = ctl; e.be = be; e.sc = CNT_W'(sc);
    exp_q.push_back(e);
  endtask

  initial begin
    //   name           rst mr ert rs rt urt br req rdy  ctl   be sc
    step("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0,  Bub,  0, 0);
    step("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 0);
    step("load_use_rs",  0, 1, 8, 8, 0, 0, 0, 0, 0,  Bub,  0, 0);
    step("after_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 1);
    step("zero_rt",      0, 1, 0, 0, 0, 1, 0, 0, 0,  Run,  0, 1);
    step("rt_unused",    0, 1, 9, 3, 9, 0, 0, 0, 0,  Run,  0, 1);
    step("load_use_rt",  0, 1, 9, 3, 9, 1, 0, 0, 0,  Bub,  0, 1);
    step("br_plus_lu",   0, 1, 8, 8, 0, 0, 1, 0, 0,  Bub,  0, 2);
    step("br_flush",     0, 0, 0, 0, 0, 0, 1, 0, 0,  Flu,  0, 3);
    step("idle2",        0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 3);
    // memory wait: ready low 3 cycles then high
    step("mem_start",    0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 3);
    step("mem_w1_ign",   0, 1, 8, 8, 0, 0, 1, 1, 0,  Hold, 0, 4);
    step("mem_w2",       0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 5);
    step("mem_done",     0, 0, 0, 0, 0, 0, 0, 1, 1,  Hold, 0, 6);
    step("mem_back_run", 0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 7);
    step("mem_fast",     0, 0, 0, 0, 0, 0, 0, 1, 1,  Run,  0, 7);
    // mem_req dropped mid-wait counts as completion
    step("drop_start",   0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 7);
    step("drop_req",     0, 0, 0, 0, 0, 0, 0, 0, 0,  Hold, 0, 8);
    step("drop_run",     0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 9);
    // timeout: RUN stall then wait_cnt 1..4, ERROR on the fourth wait cycle
    step("to_start",     0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 9);
    step("to_w1",        0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 10);
    step("to_w2",        0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 11);
    step("to_w3",        0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 12);
    step("to_w4",        0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 13);
    step("err_enter",    0, 0, 0, 0, 0, 0, 0, 1, 0,  Err,  1, 14);
    step("err_sat",      0, 0, 0, 0, 0, 0, 0, 1, 1,  Err,  1, 15);
    for (int i = 0; i < 20; i++) begin
      step("err_hold",   0, 1, 8, 8, 0, 0, 1, 0, 1,  Err,  1, 15);
    end
    step("err_reset",    1, 0, 0, 0, 0, 0, 0, 0, 0,  Bub,  1, 15);
    step("post_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 0);
    // reset mid-wait must discard the partial count
    step("rw_start",     0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 0);
    step("rw_w1",        0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 1);
    step("rw_reset",     1, 0, 0, 0, 0, 0, 0, 1, 0,  Bub,  0, 2);
    step("rw_run",       0, 0, 0, 0, 0, 0, 0, 0, 0,  Run,  0, 0);
    step("rw2_start",    0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 0);
    step("rw2_w1",       0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 1);
    step("rw2_w2",       0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 2);
    step("rw2_w3",       0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 3);
    step("rw2_w4",       0, 0, 0, 0, 0, 0, 0, 1, 0,  Hold, 0, 4);
    step("rw2_err",      0, 0, 0, 0, 0, 0, 0, 1, 0,  Err,  1, 5);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush sequencer for the 5-stage pipelined datapath. It watches the ID/EX/MEM stage state and drives the write enables of the PC and IF/ID register, the ID/EX control-bubble select, the IF/ID flush and the pipeline hold.
It resolves load-use hazards, taken-branch flushes, and multi-cycle data-memory waits through a req/ready handshake with a timeout. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 64, max consecutive cycles in MEM_WAIT before entering ERROR (range 1..2^TO_W-1)
TO_W, 7, width of the wait-cycle counter
CNT_W, 16, width of the stall_count output

Ports:
clk  input  1  single pipeline clock, rising edge
reset  input  1  synchronous, active-high
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt (R-type, BEQ, SW)
ex_memRead  input  1  memRead bit of the ID/EX MEM control group
ex_rt  input  5  destination rt of the instruction in EX
branch_taken  input  1  BEQ resolved taken in ID this cycle
mem_req  input  1  MEM stage performs memRead or memWrite
mem_ready  input  1  data memory completes the access this cycle
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
idex_bubble  output  1  forces the EX/MEM/WB control groups to zero into ID/EX
ifid_flush  output  1  zeroes IF/ID on the next edge
pipe_hold  output  1  freezes ID/EX, EX/MEM and MEM/WB
bus_error  output  1  sticky memory-timeout flag
stall_count  output  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- States: RUN, MEM_WAIT, ERROR. All outputs are combinational from the state and inputs. State, wait counter, stall_count and bus_error are registered.
- Reset (sampled at posedge): state=RUN, wait_cnt=0, stall_count=0, bus_error=0. While reset is high, outputs are pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_hold=0.
- Definition: load_use = ex_memRead & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN, evaluated in priority order:
  - (1) mem_req & !mem_ready: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=0, ifid_flush=0. Next state MEM_WAIT; wait_cnt is set to 1 on that edge.
  - (2) load_use: pc_write=0, ifid_write=0, idex_bubble=1, pipe_hold=0, ifid_flush=0. Stay in RUN; this is exactly a one-cycle bubble.
  - (3) branch_taken: pc_write=1, ifid_write=1, ifid_flush=1.
  - (4) Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- A branch coincident with load_use or a memory wait is suppressed (no flush). It is re-resolved when ID re-evaluates after the stall.
- MEM_WAIT: same outputs as RUN case (1); load_use and branch_taken are ignored.
  - mem_ready=1: outputs are still frozen this cycle, the access completes, next state RUN, wait_cnt cleared.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT: next state ERROR, bus_error set.
  - Otherwise wait_cnt increments.
- ERROR: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=1, ifid_flush=0. Only reset exits this state; bus_error stays 1.
- stall_count increments on every non-reset cycle with pc_write=0, including ERROR cycles. It saturates at 2^CNT_W-1 and does not wrap.
- Deasserting mem_req while in MEM_WAIT is a protocol violation. It is treated as mem_ready=1.
- Reset during MEM_WAIT or ERROR returns to RUN on the next edge. Any partially counted wait is discarded.

Test Plan:
- Load-use: ex_memRead=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_count=1.
- $zero/unused-rt filter: ex_rt=0, id_rs=0 -> no stall. Then ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Branch plus hazard: branch_taken=1 with load_use=1 -> ifid_flush=0 and bubble=1. Next cycle branch_taken=1, no hazard -> ifid_flush=1, pc_write=1.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles then high -> pipe_hold=1 for 4 cycles, return to RUN, stall_count=4.
- Timeout with MEM_TIMEOUT=4: mem_ready held low -> ERROR entered after 4 wait cycles, bus_error=1 stays set, outputs frozen. reset for 1 cycle -> RUN, bus_error=0, stall_count=0.
- Saturation with CNT_W=4: hold in ERROR for 20 cycles -> stall_count=15 and stays at 15.
